tim_arbiter: RTL and testbench



---
 rtl/tim_arbiter.sv | 129 ++++++++++++
 tb/tb_tim_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tim_arbiter.sv
// Two-master front end for one TIM port: forwards single-cycle requests, parks a colliding one
// in a one-entry skid and routes each one-cycle-latency response back to its originator.
package tim_arbiter_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic        mem_error;
  } mem_out_type;

endpackage

module tim_arbiter
  import tim_arbiter_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  m0_in,
  input  mem_in_type  m1_in,
  output mem_out_type m0_out,
  output mem_out_type m1_out,
  output mem_in_type  tim_in,
  input  mem_out_type tim_out
);

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  function automatic master_e other(input master_e id);
    return (id == M0) ? M1 : M0;
  endfunction

  logic       pend_v;
  master_e    pend_id;
  mem_in_type pend_req;
  logic       inflight_v;
  master_e    inflight_id;
  master_e    rr;

  logic       issue_v;
  master_e    issue_id;
  mem_in_type issue_req;
  logic       pend_v_n;
  master_e    pend_id_n;
  mem_in_type pend_req_n;
  master_e    rr_n;
  logic       own_req;
  logic       other_req;

  assign own_req   = (pend_id == M0) ? m0_in.mem_valid : m1_in.mem_valid;
  assign other_req = (pend_id == M0) ? m1_in.mem_valid : m0_in.mem_valid;

  always_comb begin
    issue_v    = 1'b0;
    issue_id   = M0;
    issue_req  = '0;
    pend_v_n   = 1'b0;
    pend_id_n  = pend_id;
    pend_req_n = pend_req;
    rr_n       = rr;
    // Gating on reset keeps tim_in at zero while reset is held, even if masters pulse.
    if (reset) begin
      if (pend_v) begin
        issue_v   = 1'b1;
        issue_id  = pend_id;
        issue_req = pend_req;
        if (other_req) begin
          pend_v_n   = 1'b1;
          pend_id_n  = other(pend_id);
          pend_req_n = (pend_id == M0) ? m1_in : m0_in;
        end
      end else if (m0_in.mem_valid && m1_in.mem_valid) begin
        issue_v    = 1'b1;
        issue_id   = rr;
        issue_req  = (rr == M0) ? m0_in : m1_in;
        pend_v_n   = 1'b1;
        pend_id_n  = other(rr);
        pend_req_n = (rr == M0) ? m1_in : m0_in;
        rr_n       = other(rr);
      end else if (m0_in.mem_valid) begin
        issue_v   = 1'b1;
        issue_id  = M0;
        issue_req = m0_in;
      end else if (m1_in.mem_valid) begin
        issue_v   = 1'b1;
        issue_id  = M1;
        issue_req = m1_in;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_v      <= 1'b0;
      pend_id     <= M0;
      pend_req    <= '0;
      inflight_v  <= 1'b0;
      inflight_id <= M0;
      rr          <= master_e'(RR_INIT);
    end else begin
      pend_v      <= pend_v_n;
      pend_id     <= pend_id_n;
      pend_req    <= pend_req_n;
      inflight_v  <= issue_v;
      inflight_id <= issue_id;
      rr          <= rr_n;
    end
  end

  assign tim_in = issue_req;
  assign m0_out = (inflight_v && inflight_id == M0) ? tim_out : '0;
  assign m1_out = (inflight_v && inflight_id == M1) ? tim_out : '0;

  // A master re-pulsing while its own request still sits in the skid is dropped.
  ap_no_skid_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(pend_v && own_req));

endmodule

// File: tb/tb_tim_arbiter.sv
// Bench for tim_arbiter: directed scenarios plus random traffic against a queue-based
// service-order model and a reference memory.
module tb_tim_arbiter;
  import tim_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  mem_in_type  m0_in, m1_in, tim_in;
  mem_out_type m0_out, m1_out, tim_out;
  logic        force_ready;

  tim_arbiter #(.RR_INIT(1'b0)) dut (
    .clock  (clock),
    .reset  (reset),
    .m0_in  (m0_in),
    .m1_in  (m1_in),
    .m0_out (m0_out),
    .m1_out (m1_out),
    .tim_in (tim_in),
    .tim_out(tim_out)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] init_word(input int i);
    return {16'hC0DE, 16'(i), 32'(i * 7 + 3)};
  endfunction

  // TIM stand-in: one-cycle latency, read returns pre-write data, error on addr bit 12.
  logic [63:0] tim_mem [256];
  always @(posedge clock) begin
    tim_out.mem_ready <= tim_in.mem_valid | force_ready;
    tim_out.mem_rdata <= tim_mem[tim_in.mem_addr[10:3]];
    tim_out.mem_error <= tim_in.mem_valid & tim_in.mem_addr[12];
    if (tim_in.mem_valid)
      for (int b = 0; b < 8; b++)
        if (tim_in.mem_wstrb[b]) tim_mem[tim_in.mem_addr[10:3]][b*8 +: 8] <= tim_in.mem_wdata[b*8 +: 8];
  end

  typedef struct {
    int         id;
    mem_in_type req;
  } entry_t;

  entry_t      q[$];
  logic [63:0] ref_mem [256];
  mem_out_type exp_out [2];
  bit          mrr;
  bit          busy [2];
  int          pulse_cyc [2];
  int          npulse [2];
  int          nready [2];
  int          cyc = 0;
  int          passed = 0;
  int          total = 0;
  int          failed = 0;

  task automatic check(input string tag, input logic [136:0] obs, input logic [136:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic mem_in_type mk(input logic [63:0] addr, input logic [63:0] wdata,
                                    input logic [7:0] wstrb);
    mem_in_type r;
    r.mem_valid = 1'b1;
    r.mem_addr  = addr;
    r.mem_wdata = wdata;
    r.mem_wstrb = wstrb;
    return r;
  endfunction

  function automatic mem_out_type mo(input int i);
    return (i == 1) ? m1_out : m0_out;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_out[0] = '0;
    exp_out[1] = '0;
    mrr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      busy[i] = 1'b0;
      npulse[i] = 0;
      nready[i] = 0;
    end
  endtask

  // One clock: check responses, apply pulses (only for idle masters), predict tim_in.
  task automatic step(input bit p0, input mem_in_type r0, input bit p1, input mem_in_type r1);
    bit         p [2];
    mem_in_type r [2];
    mem_in_type exp_tim;
    entry_t     e;
    int         idx;
    @(posedge clock);
    #1;
    cyc++;
    check("m0_out", m0_out, exp_out[0]);
    check("m1_out", m1_out, exp_out[1]);
    for (int i = 0; i < 2; i++) begin
      if (mo(i).mem_ready === 1'b1) begin
        check("latency", 1'((cyc - pulse_cyc[i]) inside {1, 2}), 1'b1);
        busy[i] = 1'b0;
        nready[i]++;
      end
    end
    p[0] = p0 && !busy[0];
    p[1] = p1 && !busy[1];
    r[0] = r0;
    r[1] = r1;
    m0_in = p[0] ? r0 : '0;
    m1_in = p[1] ? r1 : '0;
    for (int i = 0; i < 2; i++) begin
      if (p[i]) begin
        busy[i] = 1'b1;
        pulse_cyc[i] = cyc;
        npulse[i]++;
      end
    end
    if (p[0] && p[1] && q.size() == 0) begin
      q.push_back('{id: int'(mrr), req: r[mrr]});
      q.push_back('{id: int'(!mrr), req: r[!mrr]});
      mrr = !mrr;
    end else begin
      for (int i = 0; i < 2; i++)
        if (p[i]) q.push_back('{id: i, req: r[i]});
    end
    exp_out[0] = '0;
    exp_out[1] = '0;
    exp_tim = '0;
    if (q.size() > 0) begin
      e = q.pop_front();
      idx = int'(e.req.mem_addr[10:3]);
      exp_tim = e.req;
      exp_out[e.id].mem_ready = 1'b1;
      exp_out[e.id].mem_rdata = ref_mem[idx];
      exp_out[e.id].mem_error = e.req.mem_addr[12];
      for (int b = 0; b < 8; b++)
        if (e.req.mem_wstrb[b]) ref_mem[idx][b*8 +: 8] = e.req.mem_wdata[b*8 +: 8];
    end
    #1;
    check("tim_in", tim_in, exp_tim);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    mem_in_type  ra, rb;
    int          total_pulses;
    int          budget;
    for (int i = 0; i < 256; i++) begin
      tim_mem[i] <= init_word(i);
      ref_mem[i] = init_word(i);
    end
    reset = 1'b0;
    force_ready = 1'b0;
    m0_in = '0;
    m1_in = '0;
    model_reset();
    #2;
    check("reset_m0_out", m0_out, '0);
    check("reset_m1_out", m1_out, '0);
    check("reset_tim_in", tim_in, '0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // single read forwarded the same cycle
    step(1'b1, mk(64'h40, '0, 8'h00), 1'b0, '0);
    check("fwd_addr", tim_in.mem_addr, 64'h40);
    idle();
    check("fwd_ready", m0_out.mem_ready, 1'b1);
    check("fwd_rdata", m0_out.mem_rdata, init_word(8));
    check("fwd_m1_quiet", m1_out, '0);

    // collision, master 0 wins first
    step(1'b1, mk(64'h8, 64'h1122334455667788, 8'hFF), 1'b1, mk(64'h10, '0, 8'h00));
    check("col1_first", tim_in.mem_addr, 64'h8);
    idle();
    check("col1_second", tim_in.mem_addr, 64'h10);
    check("col1_m0_ready", m0_out.mem_ready, 1'b1);
    idle();
    check("col1_m1_ready", m1_out.mem_ready, 1'b1);
    check("col1_m1_rdata", m1_out.mem_rdata, init_word(2));

    // second collision, master 1 wins; master 0 sees the earlier write
    step(1'b1, mk(64'h8, '0, 8'h00), 1'b1, mk(64'h18, '0, 8'h00));
    check("col2_first", tim_in.mem_addr, 64'h18);
    idle();
    check("col2_second", tim_in.mem_addr, 64'h8);
    idle();
    check("col2_m0_ready", m0_out.mem_ready, 1'b1);
    check("col2_m0_rdata", m0_out.mem_rdata, 64'h1122334455667788);

    // m1 parked while m0 re-pulses on its ready cycle
    step(1'b1, mk(64'h20, '0, 8'h00), 1'b1, mk(64'h28, 64'hAA, 8'h01));
    step(1'b1, mk(64'h30, '0, 8'h00), 1'b0, '0);
    check("skid_m1_issued", tim_in.mem_addr, 64'h28);
    idle();
    check("skid_m0_issued", tim_in.mem_addr, 64'h30);
    idle();
    check("skid_m0_ready", m0_out.mem_ready, 1'b1);

    // reset while a request is parked and another is in flight
    step(1'b1, mk(64'h48, '0, 8'h00), 1'b1, mk(64'h50, '0, 8'h00));
    @(posedge clock);
    #1;
    reset = 1'b0;
    m0_in = mk(64'h58, '0, 8'h00);
    m1_in = '0;
    #1;
    check("rst_mid_m0_out", m0_out, '0);
    check("rst_mid_m1_out", m1_out, '0);
    check("rst_mid_tim_in", tim_in, '0);
    m0_in = '0;
    force_ready = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = tim_mem[i];
    idle();
    idle();
    force_ready = 1'b0;
    idle();

    // random traffic obeying the one-outstanding rule
    total_pulses = 0;
    budget = 0;
    while (total_pulses < 1000 && budget < 20000) begin
      ra = mk({32'h0, $urandom & 32'h1FF8}, {$urandom, $urandom}, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom));
      rb = mk({32'h0, $urandom & 32'h1FF8}, {$urandom, $urandom}, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom));
      step($urandom_range(0, 3) != 0, ra, $urandom_range(0, 3) != 0, rb);
      total_pulses = npulse[0] + npulse[1];
      budget++;
    end
    check("random_budget", 1'(budget < 20000), 1'b1);
    repeat (3) idle();
    check("m0_ready_count", npulse[0], nready[0]);
    check("m1_ready_count", npulse[1], nready[1]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
